// File: rtl/divider_8bit_if.sv
// Operand/result bundle for the sequential 8-bit restoring divider.
// The master drives the operands and controls. The slave returns the registered results.
interface divider_8bit_if;
   logic       run;
   logic       clear_a_load_b;
   logic [7:0] sw;
   logic [7:0] aval;
   logic [7:0] bval;
   logic [7:0] dval;
   logic       done;
   logic       div_zero;

   modport master (
      output run, clear_a_load_b, sw,
      input  aval, bval, dval, done, div_zero
   );

   modport slave (
      input  run, clear_a_load_b, sw,
      output aval, bval, dval, done, div_zero
   );
endinterface

// File: rtl/divider_8bit.sv
// Unsigned 8-bit restoring divider: A = partial remainder, B = dividend/quotient, D = divisor.
// Each of the eight iterations is one SHIFT state followed by one SUB state.
module divider_8bit (
   input  logic          clk_i,
   input  logic          rst_i,
   divider_8bit_if.slave bus
);

   // The encoding is sequential, so SHIFTk = 2k and SUBk = 2k+1.
   // The iteration states can therefore advance by incrementing the state.
   typedef enum logic [4:0] {
      S_IDLE, S_LOAD,
      S_SH1, S_SUB1, S_SH2, S_SUB2, S_SH3, S_SUB3, S_SH4, S_SUB4,
      S_SH5, S_SUB5, S_SH6, S_SUB6, S_SH7, S_SUB7, S_SH8, S_SUB8,
      S_DONE
   } state_e;

   state_e     state_q, state_d;
   logic [8:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [7:0] d_q, d_d;
   logic       dz_q, dz_d;
   logic [9:0] trial;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         d_q     <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         d_q     <= d_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      d_d     = d_q;
      dz_d    = dz_q;
      trial   = {1'b0, a_q} - {2'b00, d_q};
      case (state_q)
         S_IDLE: begin
            if (bus.clear_a_load_b) begin
               b_d  = bus.sw;
               a_d  = '0;
               dz_d = 1'b0;
            end
            if (bus.run) state_d = S_LOAD;
         end
         S_LOAD: begin
            a_d     = '0;
            d_d     = bus.sw;
            dz_d    = (bus.sw == 8'd0);
            state_d = S_SH1;
         end
         S_DONE: begin
            if (!bus.run) state_d = S_IDLE;
         end
         default: begin
            if (!state_q[0]) begin
               a_d = {a_q[7:0], b_q[7]};
               b_d = {b_q[6:0], 1'b0};
            end else if (!trial[9]) begin
               // The subtraction fits, so keep the difference.
               // On a borrow, A is left unchanged, which is the restore.
               a_d    = trial[8:0];
               b_d[0] = 1'b1;
            end else begin
               b_d[0] = 1'b0;
            end
            state_d = state_e'(state_q + 5'd1);
         end
      endcase
   end

   assign bus.aval     = a_q[7:0];
   assign bus.bval     = b_q;
   assign bus.dval     = d_q;
   assign bus.done     = (state_q == S_DONE);
   assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_divider_8bit.sv
// Directed bench for divider_8bit.
// Covers the result values, latency, divide-by-zero, rerun, held Run and asynchronous reset.
module tb_divider_8bit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errs = 0;
   int   checks = 0;

   divider_8bit_if dif ();
   divider_8bit dut (.clk_i(clk), .rst_i(rst), .bus(dif.slave));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] v);
      dif.sw = v;
      dif.clear_a_load_b = 1'b1;
      tick();
      dif.clear_a_load_b = 1'b0;
   endtask

   // Starts a division and checks the Done timing.
   // Done must be low after edge 16 and high after edge 18, where edge 0 samples Run.
   // Run is left high on return.
   task automatic start_and_wait(input logic [7:0] dvsr, input string tag);
      dif.sw = dvsr;
      dif.run = 1'b1;
      tick();
      for (int n = 1; n <= 18; n++) begin
         tick();
         if (n == 16) begin
            checks++;
            if (dif.done !== 1'b0) begin
               errs++;
               $display("FAIL %s early_done: got %b want 0", tag, dif.done);
            end
         end
      end
      checks++;
      if (dif.done !== 1'b1) begin
         errs++;
         $display("FAIL %s done_at_18: got %b want 1", tag, dif.done);
      end
   endtask

   task automatic release_run();
      dif.run = 1'b0;
      tick();
      checks++;
      if (dif.done !== 1'b0) begin
         errs++;
         $display("FAIL back_to_idle: done got %b want 0", dif.done);
      end
   endtask

   task automatic check_res(input string tag, input logic [7:0] q, input logic [7:0] r,
                            input logic [7:0] d, input logic dz);
      checks++;
      if (dif.bval !== q) begin
         errs++;
         $display("FAIL %s quotient: got %0d want %0d", tag, dif.bval, q);
      end
      checks++;
      if (dif.aval !== r) begin
         errs++;
         $display("FAIL %s remainder: got %0d want %0d", tag, dif.aval, r);
      end
      checks++;
      if (dif.dval !== d) begin
         errs++;
         $display("FAIL %s divisor: got %0d want %0d", tag, dif.dval, d);
      end
      checks++;
      if (dif.div_zero !== dz) begin
         errs++;
         $display("FAIL %s divzero: got %b want %b", tag, dif.div_zero, dz);
      end
   endtask

   task automatic check_zero(input string tag);
      checks++;
      if ({dif.aval, dif.bval, dif.dval, dif.done, dif.div_zero} !== 26'd0) begin
         errs++;
         $display("FAIL %s all_zero: got a=%h b=%h d=%h done=%b dz=%b want all 0",
                  tag, dif.aval, dif.bval, dif.dval, dif.done, dif.div_zero);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      check_zero("reset");
      rst = 1'b0;
      tick();
      check_zero("after_reset");
   endtask

   task automatic test_basic();
      load(8'd100);
      start_and_wait(8'd7, "100/7");
      check_res("100/7", 8'd14, 8'd2, 8'd7, 1'b0);
   endtask

   // Divides the previous quotient again, because no reload happens in between.
   task automatic test_rerun();
      release_run();
      start_and_wait(8'd7, "rerun");
      check_res("rerun 14/7", 8'd2, 8'd0, 8'd7, 1'b0);
      release_run();
   endtask

   task automatic test_boundaries();
      load(8'd255);
      start_and_wait(8'd1, "255/1");
      check_res("255/1", 8'd255, 8'd0, 8'd1, 1'b0);
      release_run();
      load(8'd5);
      start_and_wait(8'd9, "5/9");
      check_res("5/9", 8'd0, 8'd5, 8'd9, 1'b0);
      release_run();
   endtask

   task automatic test_div_zero();
      load(8'd200);
      start_and_wait(8'd0, "200/0");
      check_res("200/0", 8'hFF, 8'd200, 8'd0, 1'b1);
      release_run();
      load(8'd33);
      checks++;
      if (dif.div_zero !== 1'b0 || dif.bval !== 8'd33) begin
         errs++;
         $display("FAIL clear_divzero: got dz=%b b=%0d want dz=0 b=33", dif.div_zero, dif.bval);
      end
   endtask

   // ClearA_LoadB toggles during the iterations and again in DONE, and must have no effect.
   task automatic test_hold_done();
      load(8'd100);
      dif.sw = 8'd7;
      dif.run = 1'b1;
      tick();
      tick();
      dif.sw = 8'hAA;
      for (int n = 2; n <= 18; n++) begin
         dif.clear_a_load_b = ~dif.clear_a_load_b;
         tick();
      end
      check_res("toggle_run", 8'd14, 8'd2, 8'd7, 1'b0);
      for (int n = 0; n < 50; n++) begin
         dif.clear_a_load_b = ~dif.clear_a_load_b;
         tick();
         checks++;
         if (dif.done !== 1'b1 || dif.bval !== 8'd14 || dif.aval !== 8'd2) begin
            errs++;
            $display("FAIL hold_done cyc%0d: got done=%b b=%0d a=%0d want 1/14/2",
                     n, dif.done, dif.bval, dif.aval);
         end
      end
      dif.clear_a_load_b = 1'b0;
      release_run();
   endtask

   task automatic test_async_reset();
      load(8'd100);
      dif.sw = 8'd7;
      dif.run = 1'b1;
      tick();
      for (int n = 0; n < 9; n++) tick();
      dif.run = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_reset");
      #1;
      rst = 1'b0;
      tick();
      tick();
      tick();
      check_zero("idle_wait");
      load(8'd100);
      start_and_wait(8'd7, "post_reset");
      check_res("post_reset", 8'd14, 8'd2, 8'd7, 1'b0);
      release_run();
   endtask

   initial begin
      dif.run = 1'b0;
      dif.clear_a_load_b = 1'b0;
      dif.sw = 8'd0;
      test_reset();
      test_basic();
      test_rerun();
      test_boundaries();
      test_div_zero();
      test_hold_done();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
